duration_encoder: RTL and testbench

Measures how long a note gate is held, in prescaler ticks, and quantises the result to the nearest 4-bit duration code. This is the inverse of the code-to-duration lookup: at 6000 ticks per beat, code 5 (crotchet) is 6000 ticks. It sits on the record/capture path between the note-entry logic and the score memory writer. Results go out through a single-entry valid/ready buffer.

---
 rtl/duration_encoder_pkg.sv | 54 +++++
 rtl/duration_encoder_classifier.sv | 28 ++
 rtl/duration_encoder.sv | 113 +++++++++++
 tb/tb_duration_encoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/duration_encoder_pkg.sv
// Shared duration definitions: note lengths in ticks, quantiser midpoints,
// code values and encoder FSM states.
package duration_encoder_pkg;

  localparam int unsigned TICKS_PER_BEAT = 6000;

  // Nominal note lengths in ticks, indexed by code (code 5 = one beat)
  localparam int unsigned DUR_UNDEF           = 1000;
  localparam int unsigned DUR_SEMIQUAVER      = 1500;
  localparam int unsigned DUR_TRIPLET_QUAVER  = 2000;
  localparam int unsigned DUR_QUAVER          = 3000;
  localparam int unsigned DUR_DOTTED_QUAVER   = 4500;
  localparam int unsigned DUR_CROTCHET        = TICKS_PER_BEAT;
  localparam int unsigned DUR_DOTTED_CROTCHET = 9000;
  localparam int unsigned DUR_MINIM           = 12000;
  localparam int unsigned DUR_DOTTED_MINIM    = 18000;
  localparam int unsigned DUR_SEMIBREVE       = 24000;
  localparam int unsigned DUR_BREVE           = 48000;

  // Lower bound of codes 1..10; each is the midpoint of neighbouring lengths
  localparam int unsigned NUM_THRESH = 10;
  localparam int unsigned THRESH [NUM_THRESH] = '{
    (DUR_UNDEF           + DUR_SEMIQUAVER)      / 2,
    (DUR_SEMIQUAVER      + DUR_TRIPLET_QUAVER)  / 2,
    (DUR_TRIPLET_QUAVER  + DUR_QUAVER)          / 2,
    (DUR_QUAVER          + DUR_DOTTED_QUAVER)   / 2,
    (DUR_DOTTED_QUAVER   + DUR_CROTCHET)        / 2,
    (DUR_CROTCHET        + DUR_DOTTED_CROTCHET) / 2,
    (DUR_DOTTED_CROTCHET + DUR_MINIM)           / 2,
    (DUR_MINIM           + DUR_DOTTED_MINIM)    / 2,
    (DUR_DOTTED_MINIM    + DUR_SEMIBREVE)       / 2,
    (DUR_SEMIBREVE       + DUR_BREVE)           / 2
  };

  // Gates shorter than half the shortest length count as key bounce
  localparam int unsigned DEBOUNCE_TICKS = DUR_UNDEF / 2;

  localparam logic [3:0] CODE_UNDEF           = 4'd0;
  localparam logic [3:0] CODE_SEMIQUAVER      = 4'd1;
  localparam logic [3:0] CODE_TRIPLET_QUAVER  = 4'd2;
  localparam logic [3:0] CODE_QUAVER          = 4'd3;
  localparam logic [3:0] CODE_DOTTED_QUAVER   = 4'd4;
  localparam logic [3:0] CODE_CROTCHET        = 4'd5;
  localparam logic [3:0] CODE_DOTTED_CROTCHET = 4'd6;
  localparam logic [3:0] CODE_MINIM           = 4'd7;
  localparam logic [3:0] CODE_DOTTED_MINIM    = 4'd8;
  localparam logic [3:0] CODE_SEMIBREVE       = 4'd9;
  localparam logic [3:0] CODE_BREVE           = 4'd10;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MEASURE  = 2'd1;
  localparam logic [1:0] ST_CLASSIFY = 2'd2;

endpackage

// File: rtl/duration_encoder_classifier.sv
// duration_classifier: combinational tick-count to duration-code quantiser.
// A count equal to a midpoint takes the upper code; all-ones means the
// counter saturated and always maps to the longest code.
module duration_classifier
  import duration_encoder_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] count_i,
  output logic [3:0]   code_o
);

  logic [31:0] count_w;
  logic        sat;

  assign count_w = 32'(count_i);
  assign sat     = &count_i;

  // Code = number of midpoints at or below the count
  always_comb begin
    code_o = CODE_UNDEF;
    for (int unsigned i = 0; i < NUM_THRESH; i++) begin
      if (count_w >= THRESH[i]) code_o = 4'(i + 1);
    end
    if (sat) code_o = CODE_BREVE;
  end

endmodule

// File: rtl/duration_encoder.sv
// duration_encoder: measures gate length in ticks, quantises it to a
// duration code and presents it through a single-entry valid/ready buffer.
// Optional macro DURATION_ENC_DEBOUNCE_EN: silently discard very short gates.
module duration_encoder
  import duration_encoder_pkg::*;
#(
  parameter int unsigned TICK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              gate_in,
  output logic [3:0]        code_out,
  output logic [TICK_W-1:0] duration_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              drop
);

  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] count_q, count_d;
  logic              gate_q;
  logic [3:0]        code_q, code_d;
  logic [TICK_W-1:0] dur_q, dur_d;
  logic              valid_q, valid_d;
  logic              drop_q, drop_d;

  logic              rise;
  logic              bounce;
  logic [3:0]        class_code;

  assign rise = gate_in & ~gate_q;

`ifdef DURATION_ENC_DEBOUNCE_EN
  assign bounce = (32'(count_q) < DEBOUNCE_TICKS);
`else
  assign bounce = 1'b0;
`endif

  duration_classifier #(.W(TICK_W)) u_classifier (
    .count_i (count_q),
    .code_o  (class_code)
  );

  // FSM, saturating counter and output buffer next-state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    code_d  = code_q;
    dur_d   = dur_q;
    valid_d = valid_q;
    drop_d  = 1'b0;

    // A transfer empties the buffer; a load in CLASSIFY overrides this below
    if (valid_q && code_ready) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
          count_d = '0;
        end
      end
      ST_MEASURE: begin
        if (gate_in) begin
          if (tick && !(&count_q)) count_d = count_q + 1'b1;
        end else begin
          state_d = ST_CLASSIFY;
        end
      end
      ST_CLASSIFY: begin
        state_d = ST_IDLE;
        if (bounce) begin
          // discarded quietly: no load, no drop
        end else if (!valid_q || code_ready) begin
          code_d  = class_code;
          dur_d   = count_q;
          valid_d = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; gate history resets high so a held gate needs re-pressing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      gate_q  <= 1'b1;
      code_q  <= CODE_UNDEF;
      dur_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gate_q  <= gate_in;
      code_q  <= code_d;
      dur_q   <= dur_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign code_out     = code_q;
  assign duration_out = dur_q;
  assign code_valid   = valid_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_duration_encoder.sv
// Self-checking bench for duration_encoder (and its classifier boundaries).
// Gate held for n+1 cycles with tick every cycle yields a count of n: the
// first high cycle is the IDLE cycle that detects the rise and clears count.
module tb_duration_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b1;
  logic        gate = 1'b0;
  logic        ready = 1'b1;
  logic [3:0]  code;
  logic [15:0] dur;
  logic        valid;
  logic        drop;

  logic        gate_s = 1'b0;
  logic [3:0]  s_code;
  logic [11:0] s_dur;
  logic        s_valid;
  logic        s_drop;

  logic [15:0] cls_cnt = '0;
  logic [3:0]  cls_code;

  int unsigned chk_cnt = 0;
  int unsigned pass_cnt = 0;

  always #5 clk = ~clk;

  duration_encoder #(.TICK_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .gate_in      (gate),
    .code_out     (code),
    .duration_out (dur),
    .code_valid   (valid),
    .code_ready   (ready),
    .drop         (drop)
  );

  // Narrow counter so saturation is reachable in a short run
  duration_encoder #(.TICK_W(12)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .gate_in      (gate_s),
    .code_out     (s_code),
    .duration_out (s_dur),
    .code_valid   (s_valid),
    .code_ready   (ready),
    .drop         (s_drop)
  );

  duration_classifier #(.W(16)) u_cls (
    .count_i (cls_cnt),
    .code_o  (cls_code)
  );

  typedef struct {
    logic [15:0] count;
    logic [3:0]  code;
  } cls_vec_t;

  typedef struct {
    int unsigned ticks;
    logic [3:0]  code;
  } note_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int unsigned n);
    gate = 1'b1;
    repeat (n + 1) step();
    gate = 1'b0;
  endtask

  task automatic run_note(input int unsigned n, input logic [3:0] exp_code, input string tag);
    press(n);
    step();
    check({tag, "_latency"}, 32'(valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_code"}, 32'(code), 32'(exp_code));
    check({tag, "_dur"}, 32'(dur), n);
    check({tag, "_nodrop"}, 32'(drop), 32'd0);
    step();
    check({tag, "_valid_clr"}, 32'(valid), 32'd0);
  endtask

  cls_vec_t  cls_tab [12];
  note_vec_t note_tab [5];

  initial begin
    cls_tab[0]  = '{16'd0,     4'd0};
    cls_tab[1]  = '{16'd1249,  4'd0};
    cls_tab[2]  = '{16'd1250,  4'd1};
    cls_tab[3]  = '{16'd1749,  4'd1};
    cls_tab[4]  = '{16'd1750,  4'd2};
    cls_tab[5]  = '{16'd3750,  4'd4};
    cls_tab[6]  = '{16'd5249,  4'd4};
    cls_tab[7]  = '{16'd7500,  4'd6};
    cls_tab[8]  = '{16'd20999, 4'd8};
    cls_tab[9]  = '{16'd35999, 4'd9};
    cls_tab[10] = '{16'd36000, 4'd10};
    cls_tab[11] = '{16'd65535, 4'd10};

    note_tab[0] = '{6000, 4'd5};
    note_tab[1] = '{1249, 4'd0};
    note_tab[2] = '{1250, 4'd1};
    note_tab[3] = '{2499, 4'd2};
    note_tab[4] = '{2500, 4'd3};

    // Reset state, with the gate already held
    gate = 1'b1;
    #1;
    check("rst_code", 32'(code), 32'd0);
    check("rst_dur", 32'(dur), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);

    for (int i = 0; i < 12; i++) begin
      cls_cnt = cls_tab[i].count;
      #1;
      check($sformatf("cls_%0d", cls_tab[i].count), 32'(cls_code), 32'(cls_tab[i].code));
    end

    repeat (3) step();
    rst = 1'b0;
    // Gate held across reset must be ignored
    repeat (10) step();
    gate = 1'b0;
    repeat (5) step();
    check("held_gate_ignored", 32'(valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_note(note_tab[i].ticks, note_tab[i].code, $sformatf("note%0d", note_tab[i].ticks));
      repeat (2) step();
    end

    // Back-pressure: second result dropped while first is held
    ready = 1'b0;
    press(3000);
    step();
    step();
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_code", 32'(code), 32'd3);
    check("bp_dur", 32'(dur), 32'd3000);
    repeat (3) step();
    gate = 1'b1;
    repeat (2000) step();
    check("bp_hold_code", 32'(code), 32'd3);
    repeat (2501) step();
    gate = 1'b0;
    step();
    check("bp_drop_early", 32'(drop), 32'd0);
    step();
    check("bp_drop", 32'(drop), 32'd1);
    check("bp_keep_code", 32'(code), 32'd3);
    check("bp_keep_dur", 32'(dur), 32'd3000);
    step();
    check("bp_drop_pulse", 32'(drop), 32'd0);
    ready = 1'b1;
    step();
    check("bp_transfer", 32'(valid), 32'd0);
    step();
    run_note(9000, 4'd6, "after_bp");
    step();

    // Reset mid-measure abandons the note
    gate = 1'b1;
    repeat (2001) step();
    rst = 1'b1;
    #1;
    check("mid_rst_code", 32'(code), 32'd0);
    check("mid_rst_dur", 32'(dur), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    gate = 1'b0;
    repeat (5) step();
    check("mid_rst_noresult", 32'(valid), 32'd0);
    check("mid_rst_nodrop", 32'(drop), 32'd0);
    run_note(1500, 4'd1, "post_rst");
    step();

    // Saturation on the 12-bit instance: all-ones maps to code 10
    gate_s = 1'b1;
    repeat (5001) step();
    gate_s = 1'b0;
    step();
    step();
    check("sat_valid", 32'(s_valid), 32'd1);
    check("sat_dur", 32'(s_dur), 32'd4095);
    check("sat_code", 32'(s_code), 32'd10);
    step();
    check("sat_valid_clr", 32'(s_valid), 32'd0);

    // Short gate
`ifdef DURATION_ENC_DEBOUNCE_EN
    press(400);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bounce_novalid", 32'(valid), 32'd0);
      check("bounce_nodrop", 32'(drop), 32'd0);
    end
`else
    run_note(400, 4'd0, "short400");
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
